// File: rtl/preg_release_queue.sv
// preg_release_queue
// ------------------
// In-order queue of stale physical-register mappings. Rename pushes the
// previous mapping of up to two destinations per cycle. Commit pops up to two
// entries per cycle in program order and pulses the freelist release ports.
// Branch checkpoints snapshot the tail pointer. A shootdown restores the tail
// from a checkpoint, so squashed entries are discarded without being freed.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   enq1/enq2, enqN_has_dest/preg   push slots (enq2 only honoured with enq1)
//   enq_ready                       room for two pushes (count <= DEPTH-2)
//   checkpoint, checkpoint_tag      save post-push tail into slot tag-1
//   commit1/commit2                 pop one/two entries (commit2 needs commit1)
//   branch_shootdown, _tag          restore tail from checkpoint slot tag-1
//   free1/free2, freeN_addr         registered release pulses to the freelist
//   count                           occupied entries
//
// Optional build macro: PRQ_TRACE_EN prints every free pulse and every
// shootdown. The logic is identical with or without the macro.

module preg_release_queue #(
  parameter int NUM_PREGS         = 64,
  parameter int DEPTH             = 32,
  parameter int MAX_PREDICT_DEPTH = 4,
  localparam int PW = $clog2(NUM_PREGS),
  localparam int AW = $clog2(DEPTH),
  localparam int TW = $clog2(MAX_PREDICT_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enq1,
  input  logic          enq2,
  input  logic          enq1_has_dest,
  input  logic          enq2_has_dest,
  input  logic [PW-1:0] enq1_preg,
  input  logic [PW-1:0] enq2_preg,
  output logic          enq_ready,
  input  logic          checkpoint,
  input  logic [TW-1:0] checkpoint_tag,
  input  logic          commit1,
  input  logic          commit2,
  input  logic          branch_shootdown,
  input  logic [TW-1:0] shootdown_branch_tag,
  output logic          free1,
  output logic          free2,
  output logic [PW-1:0] free1_addr,
  output logic [PW-1:0] free2_addr,
  output logic [AW:0]   count
);

  localparam int CW = (MAX_PREDICT_DEPTH > 1) ? $clog2(MAX_PREDICT_DEPTH) : 1;
  localparam logic [AW:0] READY_LIMIT = (AW+1)'(DEPTH - 2);
  localparam logic [TW-1:0] MAX_TAG   = TW'(MAX_PREDICT_DEPTH);

  logic          has_dest_mem [DEPTH];
  logic [PW-1:0] preg_mem     [DEPTH];

  logic [AW:0]   head_q, head_d;
  logic [AW:0]   tail_q, tail_d;
  logic [AW:0]   ckpt_q [MAX_PREDICT_DEPTH];

  logic          free1_q, free2_q;
  logic [PW-1:0] free1_addr_q, free2_addr_q;

  logic [AW:0]   cnt_s;
  logic          ready_s;
  logic          sd_valid_s, ck_valid_s;
  logic [CW-1:0] sd_idx_s, ck_idx_s;
  logic          push1_s, push2_s, pop1_s, pop2_s;
  logic [AW:0]   tail_push_s;
  logic [AW-1:0] wr_idx1_s, wr_idx2_s, rd_idx1_s, rd_idx2_s;

  // Next-state computation for pointers, push/pop qualification.
  always_comb begin
    cnt_s       = tail_q - head_q;
    ready_s     = (cnt_s <= READY_LIMIT);
    sd_valid_s  = branch_shootdown && (shootdown_branch_tag != {TW{1'b0}})
                  && (shootdown_branch_tag <= MAX_TAG);
    ck_valid_s  = checkpoint && (checkpoint_tag != {TW{1'b0}})
                  && (checkpoint_tag <= MAX_TAG) && !sd_valid_s;
    sd_idx_s    = CW'(shootdown_branch_tag - TW'(1));
    ck_idx_s    = CW'(checkpoint_tag - TW'(1));
    // A shootdown drops this cycle's pushes; pushes need room for two.
    push1_s     = enq1 && ready_s && !sd_valid_s;
    push2_s     = push1_s && enq2;
    // Pops are clamped to the pre-shootdown occupancy.
    pop1_s      = commit1 && (cnt_s != {(AW+1){1'b0}});
    pop2_s      = pop1_s && commit2 && (cnt_s >= (AW+1)'(2));
    wr_idx1_s   = tail_q[AW-1:0];
    wr_idx2_s   = tail_q[AW-1:0] + AW'(1);
    rd_idx1_s   = head_q[AW-1:0];
    rd_idx2_s   = head_q[AW-1:0] + AW'(1);
    tail_push_s = tail_q + (AW+1)'(push1_s) + (AW+1)'(push2_s);
    head_d      = head_q + (AW+1)'(pop1_s) + (AW+1)'(pop2_s);
    if (sd_valid_s) begin
      tail_d = ckpt_q[sd_idx_s];
    end else begin
      tail_d = tail_push_s;
    end
  end

  // Pointer, checkpoint and release-pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q       <= {(AW+1){1'b0}};
      tail_q       <= {(AW+1){1'b0}};
      free1_q      <= 1'b0;
      free2_q      <= 1'b0;
      free1_addr_q <= {PW{1'b0}};
      free2_addr_q <= {PW{1'b0}};
      for (int i = 0; i < MAX_PREDICT_DEPTH; i++) begin
        ckpt_q[i] <= {(AW+1){1'b0}};
      end
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      free1_q      <= pop1_s && has_dest_mem[rd_idx1_s];
      free2_q      <= pop2_s && has_dest_mem[rd_idx2_s];
      free1_addr_q <= pop1_s ? preg_mem[rd_idx1_s] : {PW{1'b0}};
      free2_addr_q <= pop2_s ? preg_mem[rd_idx2_s] : {PW{1'b0}};
      if (ck_valid_s) begin
        ckpt_q[ck_idx_s] <= tail_push_s;
      end
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (reset_n && push1_s) begin
      has_dest_mem[wr_idx1_s] <= enq1_has_dest;
      preg_mem[wr_idx1_s]     <= enq1_preg;
    end
    if (reset_n && push2_s) begin
      has_dest_mem[wr_idx2_s] <= enq2_has_dest;
      preg_mem[wr_idx2_s]     <= enq2_preg;
    end
  end

`ifdef PRQ_TRACE_EN
  // Trace of release pulses and shootdowns.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (free1_q) $display("prq: freeing register: %x", free1_addr_q);
      if (free2_q) $display("prq: freeing register: %x", free2_addr_q);
      if (sd_valid_s) begin
        $display("prq: shootdown restores tail %0d, discarding %0d entries",
                 ckpt_q[sd_idx_s], tail_q - ckpt_q[sd_idx_s]);
      end
    end
  end
`endif

  assign enq_ready  = ready_s;
  assign count      = cnt_s;
  assign free1      = free1_q;
  assign free2      = free2_q;
  assign free1_addr = free1_addr_q;
  assign free2_addr = free2_addr_q;

endmodule
